// File: rtl/vector_mem_sequencer_if.sv
// -----------------------------------------------------------------------------
// vector_mem_sequencer_if
//
// Single-element data-memory port driven by the vector memory sequencer.
//
// Signals:
//   mem_req    sequencer -> memory : transfer request
//   mem_we     sequencer -> memory : 1 = write, 0 = read
//   mem_addr   sequencer -> memory : transfer address (ADDR_W)
//   mem_wdata  sequencer -> memory : write data (DATA_W)
//   mem_ready  memory -> sequencer : acknowledge; transfer completes when
//                                    mem_req and mem_ready are both high
//   mem_rdata  memory -> sequencer : read data, valid in the acknowledge cycle
//
// Modports: master (sequencer side), slave (memory side).
// -----------------------------------------------------------------------------
interface vector_mem_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/vector_mem_sequencer.sv
// -----------------------------------------------------------------------------
// vector_mem_sequencer
//
// Executes the vector memory instructions lopix (vector load) and svpix
// (vector store) as LANES single-element transfers on the data-memory port,
// freezing the pipeline while it works. Loaded elements are gathered in a
// buffer and written into the vector register file in a single cycle.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         instruction issue from decode (accepted only in IDLE)
//   is_store      1 = svpix, 0 = lopix (sampled with start)
//   base_addr     address of lane 0 (sampled with start)
//   vreg_idx      destination vector register for loads (sampled with start)
//   store_data    source vector for stores, lane i at [i*DATA_W +: DATA_W]
//   stall         pipeline freeze request (combinational)
//   busy          high in ACCESS and FINISH
//   memBus        data-memory port (master modport)
//   vec_we        one-cycle vector register write enable (loads only)
//   vec_waddr     vector register index
//   vec_wdata     assembled load vector (always the registered buffer)
//   done          one-cycle completion pulse
// -----------------------------------------------------------------------------
module vector_mem_sequencer #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      is_store,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [3:0]                vreg_idx,
    input  logic [LANES*DATA_W-1:0]   store_data,
    output logic                      stall,
    output logic                      busy,
    vector_mem_sequencer_if.master    memBus,
    output logic                      vec_we,
    output logic [3:0]                vec_waddr,
    output logic [LANES*DATA_W-1:0]   vec_wdata,
    output logic                      done
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                    state;
    state_t                    stateNext;

    logic [LANE_W-1:0]         lane;
    logic                      storeQ;
    logic [ADDR_W-1:0]         baseQ;
    logic [3:0]                vregQ;
    logic [LANES*DATA_W-1:0]   storeDataQ;
    logic [LANES*DATA_W-1:0]   loadBuf;

    logic                      busyC;
    logic                      reqC;
    logic                      doneC;
    logic                      vecWeC;
    logic                      accept;
    logic                      ack;

    // Pick one element out of a packed vector.
    function automatic logic [DATA_W-1:0] laneSlice(
        input logic [LANES*DATA_W-1:0] vec,
        input logic [LANE_W-1:0]       idx
    );
        return vec[int'(idx)*DATA_W +: DATA_W];
    endfunction

    // ---- state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // ---- next-state and control decode ----
    always_comb begin
        stateNext = state;
        busyC     = 1'b0;
        reqC      = 1'b0;
        doneC     = 1'b0;
        vecWeC    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = ACCESS;
                end
            end
            ACCESS: begin
                busyC = 1'b1;
                reqC  = 1'b1;
                if (memBus.mem_ready && (lane == LAST_LANE)) begin
                    stateNext = FINISH;
                end
            end
            FINISH: begin
                busyC     = 1'b1;
                doneC     = 1'b1;
                vecWeC    = ~storeQ;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign accept = (state == IDLE) && start;
    assign ack    = reqC && memBus.mem_ready;

    // ---- operand latch, lane counter and load buffer ----
    // The lane counter only moves on an acknowledge, which keeps the
    // request address and write data stable while memory is not ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane       <= '0;
            storeQ     <= 1'b0;
            baseQ      <= '0;
            vregQ      <= '0;
            storeDataQ <= '0;
            loadBuf    <= '0;
        end else if (accept) begin
            lane       <= '0;
            storeQ     <= is_store;
            baseQ      <= base_addr;
            vregQ      <= vreg_idx;
            storeDataQ <= store_data;
        end else if (ack) begin
            if (!storeQ) begin
                loadBuf[int'(lane)*DATA_W +: DATA_W] <= memBus.mem_rdata;
            end
            if (lane != LAST_LANE) begin
                lane <= lane + LANE_W'(1);
            end
        end
    end

    // ---- outputs ----
    // stall covers the issue cycle itself so decode holds the instruction
    // before the FSM has registered it.
    assign stall = busyC | accept;
    assign busy  = busyC;
    assign done  = doneC;

    assign memBus.mem_req   = reqC;
    assign memBus.mem_we    = reqC & storeQ;
    assign memBus.mem_addr  = reqC ? (baseQ + ADDR_W'(lane)) : '0;
    assign memBus.mem_wdata = (reqC && storeQ) ? laneSlice(storeDataQ, lane) : '0;

    assign vec_we    = vecWeC;
    assign vec_waddr = vregQ;
    assign vec_wdata = loadBuf;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vector_mem_sequencer
//
// Bench for vector_mem_sequencer (LANES=4, DATA_W=8, ADDR_W=16). Expected
// memory transfers and vector writes are queued when an instruction is issued
// and compared by a negedge monitor as the sequencer produces them; each
// scenario task adds its own timing and protocol checks.
// -----------------------------------------------------------------------------
module tb_vector_mem_sequencer;

    localparam int LANES  = 4;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } xfer_t;

    typedef struct packed {
        logic [3:0]              idx;
        logic [LANES*DATA_W-1:0] data;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic                    is_store = 1'b0;
    logic [ADDR_W-1:0]       base_addr = '0;
    logic [3:0]              vreg_idx = '0;
    logic [LANES*DATA_W-1:0] store_data = '0;
    logic                    stall;
    logic                    busy;
    logic                    vec_we;
    logic [3:0]              vec_waddr;
    logic [LANES*DATA_W-1:0] vec_wdata;
    logic                    done;

    vector_mem_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) memIf ();

    vector_mem_sequencer #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_store   (is_store),
        .base_addr  (base_addr),
        .vreg_idx   (vreg_idx),
        .store_data (store_data),
        .stall      (stall),
        .busy       (busy),
        .memBus     (memIf),
        .vec_we     (vec_we),
        .vec_waddr  (vec_waddr),
        .vec_wdata  (vec_wdata),
        .done       (done)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int doneCount   = 0;
    int vecWeCount  = 0;
    int cyc         = 0;
    int readyMode   = 0;

    xfer_t expQ[$];
    vec_t  vecQ[$];

    logic [DATA_W-1:0] memArr [0:65535];

    // Memory model: always ready, or ready one cycle in three.
    always @(posedge clk) cyc <= cyc + 1;
    assign memIf.mem_ready = (readyMode == 0) ? 1'b1 : ((cyc % 3) == 2);
    assign memIf.mem_rdata = memArr[memIf.mem_addr];

    always @(posedge clk) begin
        if (rst_n && memIf.mem_req && memIf.mem_ready && memIf.mem_we)
            memArr[memIf.mem_addr] <= memIf.mem_wdata;
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        xfer_t e;
        vec_t  v;
        if (rst_n) begin
            if (memIf.mem_req && memIf.mem_ready) begin
                vectors++;
                if (expQ.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_xfer unexpected: addr=%h we=%b wdata=%h, none required",
                             memIf.mem_addr, memIf.mem_we, memIf.mem_wdata);
                end else begin
                    e = expQ.pop_front();
                    if ({memIf.mem_addr, memIf.mem_we, memIf.mem_wdata} !== {e.addr, e.we, e.wdata}) begin
                        miscompares++;
                        $display("FAIL sb_xfer: got addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                                 memIf.mem_addr, memIf.mem_we, memIf.mem_wdata, e.addr, e.we, e.wdata);
                    end
                end
            end
            if (vec_we) begin
                vecWeCount++;
                vectors++;
                if (vecQ.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_vec unexpected: idx=%h data=%h, none required", vec_waddr, vec_wdata);
                end else begin
                    v = vecQ.pop_front();
                    if ({vec_waddr, vec_wdata, done} !== {v.idx, v.data, 1'b1}) begin
                        miscompares++;
                        $display("FAIL sb_vec: got idx=%h data=%h done=%b, required idx=%h data=%h done=1",
                                 vec_waddr, vec_wdata, done, v.idx, v.data);
                    end
                end
            end
            if (done) doneCount++;
        end
    end

    task automatic issue(input logic st, input logic [ADDR_W-1:0] b, input logic [3:0] v,
                         input logic [LANES*DATA_W-1:0] d);
        start      = 1'b1;
        is_store   = st;
        base_addr  = b;
        vreg_idx   = v;
        store_data = d;
    endtask

    task automatic pushXfer(input logic [ADDR_W-1:0] a, input logic we, input logic [DATA_W-1:0] wd);
        xfer_t x;
        x.addr = a; x.we = we; x.wdata = wd;
        expQ.push_back(x);
    endtask

    task automatic pushVec(input logic [3:0] idx, input logic [LANES*DATA_W-1:0] d);
        vec_t v;
        v.idx = idx; v.data = d;
        vecQ.push_back(v);
    endtask

    // Steps from the issue cycle (cycle 0) until done is seen; returns the
    // cycle index of done, stall cycles and wait cycles.
    task automatic runOp(input int bound, output int stallCyc, output int waitCyc, output int doneAt);
        stallCyc = 0; waitCyc = 0; doneAt = -1;
        for (int c = 0; c < bound && doneAt < 0; c++) begin
            @(negedge clk);
            if (stall) stallCyc++;
            if (memIf.mem_req && !memIf.mem_ready) waitCyc++;
            if (done) doneAt = c;
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({stall, busy, memIf.mem_req, memIf.mem_we, done, vec_we} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b, required 000000",
                     {stall, busy, memIf.mem_req, memIf.mem_we, done, vec_we});
        end
        vectors++;
        if ({memIf.mem_addr, memIf.mem_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_mem: got addr=%h wdata=%h, required 0", memIf.mem_addr, memIf.mem_wdata);
        end
        vectors++;
        if ({vec_waddr, vec_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_vec: got idx=%h data=%h, required 0", vec_waddr, vec_wdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({stall, busy, memIf.mem_req, done, vec_we} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got %b, required 00000", {stall, busy, memIf.mem_req, done, vec_we});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_basic;
        int sc, wc, da;
        memArr[16'h0010] = 8'h11; memArr[16'h0011] = 8'h22;
        memArr[16'h0012] = 8'h33; memArr[16'h0013] = 8'h44;
        for (int i = 0; i < 4; i++) pushXfer(16'h0010 + 16'(i), 1'b0, 8'h00);
        pushVec(4'd2, 32'h44332211);
        issue(1'b0, 16'h0010, 4'd2, 32'h0);
        runOp(20, sc, wc, da);
        vectors++;
        if (da !== 5) begin
            miscompares++;
            $display("FAIL load_done_cycle: got %0d, required 5", da);
        end
        vectors++;
        if (sc !== 6) begin
            miscompares++;
            $display("FAIL load_stall_cycles: got %0d, required 6", sc);
        end
        @(negedge clk);
        vectors++;
        if ({stall, busy, done, vec_we} !== 4'b0) begin
            miscompares++;
            $display("FAIL load_back_idle: got %b, required 0000", {stall, busy, done, vec_we});
        end
        vectors++;
        if (expQ.size() + vecQ.size() !== 0) begin
            miscompares++;
            $display("FAIL load_sb_drain: got %0d pending, required 0", expQ.size() + vecQ.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store_wait;
        int sc, wc, da, d0, v0;
        logic              held;
        logic [ADDR_W-1:0] pa;
        logic [DATA_W-1:0] pw;
        logic [DATA_W-1:0] want [4];
        want[0] = 8'hAA; want[1] = 8'hBB; want[2] = 8'hCC; want[3] = 8'hDD;
        for (int i = 0; i < 4; i++) pushXfer(16'h0040 + 16'(i), 1'b1, want[i]);
        d0 = doneCount; v0 = vecWeCount;
        readyMode = 1;
        issue(1'b1, 16'h0040, 4'd6, 32'hDDCCBBAA);
        sc = 0; wc = 0; da = -1; held = 1'b0; pa = '0; pw = '0;
        for (int c = 0; c < 60 && da < 0; c++) begin
            @(negedge clk);
            if (stall) sc++;
            if (held) begin
                vectors++;
                if ({memIf.mem_req, memIf.mem_we, memIf.mem_addr, memIf.mem_wdata} !== {2'b11, pa, pw}) begin
                    miscompares++;
                    $display("FAIL store_hold: got req/we=%b%b addr=%h wdata=%h, required 11 addr=%h wdata=%h",
                             memIf.mem_req, memIf.mem_we, memIf.mem_addr, memIf.mem_wdata, pa, pw);
                end
            end
            held = memIf.mem_req && !memIf.mem_ready;
            pa = memIf.mem_addr; pw = memIf.mem_wdata;
            if (held) wc++;
            if (done) da = c;
            @(posedge clk); #1;
            start = 1'b0;
        end
        readyMode = 0;
        vectors++;
        if (da < 0) begin
            miscompares++;
            $display("FAIL store_timeout: done never seen, required within 60 cycles");
        end
        vectors++;
        if (sc !== LANES + 2 + wc) begin
            miscompares++;
            $display("FAIL store_stall_cycles: got %0d, required %0d", sc, LANES + 2 + wc);
        end
        vectors++;
        if (doneCount - d0 !== 1) begin
            miscompares++;
            $display("FAIL store_done_count: got %0d, required 1", doneCount - d0);
        end
        vectors++;
        if (vecWeCount - v0 !== 0) begin
            miscompares++;
            $display("FAIL store_vec_we: got %0d pulses, required 0", vecWeCount - v0);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (memArr[16'h0040 + i] !== want[i]) begin
                miscompares++;
                $display("FAIL store_mem[%0d]: got %h, required %h", i, memArr[16'h0040 + i], want[i]);
            end
        end
    endtask

    task automatic test_wrap_load;
        int sc, wc, da;
        memArr[16'hFFFE] = 8'h5A; memArr[16'hFFFF] = 8'hA5;
        memArr[16'h0000] = 8'h3C; memArr[16'h0001] = 8'hC3;
        pushXfer(16'hFFFE, 1'b0, 8'h00);
        pushXfer(16'hFFFF, 1'b0, 8'h00);
        pushXfer(16'h0000, 1'b0, 8'h00);
        pushXfer(16'h0001, 1'b0, 8'h00);
        pushVec(4'd5, 32'hC33CA55A);
        issue(1'b0, 16'hFFFE, 4'd5, 32'h0);
        runOp(20, sc, wc, da);
        vectors++;
        if (da !== 5) begin
            miscompares++;
            $display("FAIL wrap_done_cycle: got %0d, required 5", da);
        end
    endtask

    task automatic test_back_to_back;
        int sc, wc, da;
        memArr[16'h0020] = 8'h01; memArr[16'h0021] = 8'h02;
        memArr[16'h0022] = 8'h03; memArr[16'h0023] = 8'h04;
        memArr[16'h0030] = 8'h9A; memArr[16'h0031] = 8'hBC;
        memArr[16'h0032] = 8'hDE; memArr[16'h0033] = 8'hF0;
        for (int i = 0; i < 4; i++) pushXfer(16'h0020 + 16'(i), 1'b0, 8'h00);
        pushVec(4'd1, 32'h04030201);
        issue(1'b0, 16'h0020, 4'd1, 32'h0);
        da = -1;
        for (int c = 0; c < 20 && da < 0; c++) begin
            @(negedge clk);
            if (done) da = c;
            @(posedge clk); #1;
            if (c == 1) issue(1'b1, 16'h0080, 4'd9, 32'hFFFFFFFF);
            else start = 1'b0;
        end
        vectors++;
        if (da !== 5) begin
            miscompares++;
            $display("FAIL ignore_done_cycle: got %0d, required 5", da);
        end
        // first IDLE cycle after FINISH
        for (int i = 0; i < 4; i++) pushXfer(16'h0030 + 16'(i), 1'b0, 8'h00);
        pushVec(4'd3, 32'hF0DEBC9A);
        issue(1'b0, 16'h0030, 4'd3, 32'h0);
        runOp(20, sc, wc, da);
        vectors++;
        if (da !== 5) begin
            miscompares++;
            $display("FAIL b2b_done_cycle: got %0d, required 5", da);
        end
        vectors++;
        if (sc !== 6) begin
            miscompares++;
            $display("FAIL b2b_stall_cycles: got %0d, required 6", sc);
        end
    endtask

    task automatic test_reset_midload;
        int sc, wc, da, d0, v0;
        logic found;
        memArr[16'h0050] = 8'h10; memArr[16'h0051] = 8'h20;
        memArr[16'h0052] = 8'h30; memArr[16'h0053] = 8'h40;
        for (int i = 0; i < 4; i++) pushXfer(16'h0050 + 16'(i), 1'b0, 8'h00);
        pushVec(4'd4, 32'h40302010);
        issue(1'b0, 16'h0050, 4'd4, 32'h0);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (memIf.mem_req && memIf.mem_ready && memIf.mem_addr == 16'h0051) found = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL midload_lane1: lane 1 ack not seen, required within 20 cycles");
        end
        d0 = doneCount; v0 = vecWeCount;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({stall, busy, memIf.mem_req, memIf.mem_we, done, vec_we, memIf.mem_addr, memIf.mem_wdata,
             vec_waddr, vec_wdata} !== '0) begin
            miscompares++;
            $display("FAIL midload_reset_out: got stall=%b busy=%b req=%b addr=%h vec_we=%b idx=%h data=%h, required all 0",
                     stall, busy, memIf.mem_req, memIf.mem_addr, vec_we, vec_waddr, vec_wdata);
        end
        expQ.delete();
        vecQ.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (doneCount - d0 + vecWeCount - v0 !== 0) begin
            miscompares++;
            $display("FAIL midload_no_commit: got %0d done/vec_we pulses, required 0",
                     doneCount - d0 + vecWeCount - v0);
        end
        @(posedge clk); #1;
        memArr[16'h0060] = 8'h61; memArr[16'h0061] = 8'h62;
        memArr[16'h0062] = 8'h63; memArr[16'h0063] = 8'h64;
        for (int i = 0; i < 4; i++) pushXfer(16'h0060 + 16'(i), 1'b0, 8'h00);
        pushVec(4'd7, 32'h64636261);
        issue(1'b0, 16'h0060, 4'd7, 32'h0);
        runOp(20, sc, wc, da);
        vectors++;
        if (da !== 5) begin
            miscompares++;
            $display("FAIL after_reset_done_cycle: got %0d, required 5", da);
        end
        @(negedge clk);
        vectors++;
        if (expQ.size() + vecQ.size() !== 0) begin
            miscompares++;
            $display("FAIL after_reset_sb_drain: got %0d pending, required 0", expQ.size() + vecQ.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_store_wait();
        test_wrap_load();
        test_back_to_back();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
